// File: rtl/mem_port_arbiter_if.sv
// Bundles the RAM/IO pins and the icache/LSB request channels of the memory port arbiter.
// No storage or latency; pure signal grouping.
// The master side drives requests and RAM read data, the slave side answers with done pulses.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  io_buffer_full;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_aout;
  logic                  mem_rw;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  lsb_req;
  logic                  lsb_we;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [31:0]           lsb_wdata;
  logic [2:0]            lsb_funct3;
  logic                  lsb_done;
  logic [31:0]           lsb_rdata;
  logic                  flush;
  logic                  mem_busy;

  modport slave (
    input  io_buffer_full, mem_din, if_req, if_addr, lsb_req, lsb_we, lsb_addr,
           lsb_wdata, lsb_funct3, flush,
    output mem_dout, mem_aout, mem_rw, if_done, if_data, lsb_done, lsb_rdata, mem_busy
  );

  modport master (
    output io_buffer_full, mem_din, if_req, if_addr, lsb_req, lsb_we, lsb_addr,
           lsb_wdata, lsb_funct3, flush,
    input  mem_dout, mem_aout, mem_rw, if_done, if_data, lsb_done, lsb_rdata, mem_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the byte-serial RAM/IO port between icache refill and LSB; serialises, assembles and extends.
// Latency: reads done at grant+N+2, writes done at grant+N+1 (N = 1/2/4 bytes), plus stall cycles.
// Backpressure: rdy_in low freezes everything; io_buffer_full stalls IO-region store bytes.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration on a simultaneous request tie.
module mem_port_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            cnt;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata;
  logic [31:0]           rbuf;
  logic [31:0]           if_data_q;
  logic [31:0]           lsb_rdata_q;
  logic [2:0]            funct3;
  logic                  we;
  logic                  own_lsb;
  logic                  pick_lsb;
  logic                  grant;
  logic                  io_stall;
  logic                  done_fire;
  logic [1:0]            cap_lane;
  logic [31:0]           load_ext;

  function automatic logic [2:0] width_of(input logic [1:0] w);
    case (w)
      2'b00:   width_of = 3'd1;
      2'b01:   width_of = 3'd2;
      default: width_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'h0, w[7:0]};
      3'b101:  extend = {16'h0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

`ifdef MEM_ARB_RR_EN
  logic last_if;
  assign pick_lsb = bus.lsb_req && (!bus.if_req || last_if);
`else
  assign pick_lsb = bus.lsb_req;
`endif

  assign grant    = (state == IDLE) && !bus.flush && (bus.lsb_req || bus.if_req);
  assign io_stall = we && (base >= IO_BASE) && bus.io_buffer_full;
  // The byte arriving now belongs to the address issued one cycle earlier.
  assign cap_lane = cnt[1:0] - 2'd1;
  assign load_ext = extend(funct3, rbuf);

  // State register: frozen while rdy_in is low.
  always_ff @(posedge clk) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next state: RD spends N address cycles plus one drain cycle for the last byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = (pick_lsb && bus.lsb_we) ? WR : RD;
      RD: begin
        if (bus.flush)          state_nxt = IDLE;
        else if (cnt == nbytes) state_nxt = DONE;
      end
      WR:   if (!io_stall && (cnt == nbytes - 3'd1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pins driven from the byte counter; done pulses gated by rdy_in and read flush.
  always_comb begin
    done_fire    = (state == DONE) && rdy_in && (we || !bus.flush);
    bus.mem_rw   = 1'b0;
    bus.mem_aout = '0;
    bus.mem_dout = 8'h0;
    case (state)
      RD: if (cnt != nbytes) bus.mem_aout = base + ADDR_WIDTH'(cnt);
      WR: begin
        bus.mem_aout = base + ADDR_WIDTH'(cnt);
        bus.mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        bus.mem_rw   = rdy_in && !io_stall;
      end
      default: ;
    endcase
    bus.if_done   = done_fire && !own_lsb;
    bus.lsb_done  = done_fire && own_lsb;
    bus.if_data   = bus.if_done ? rbuf : if_data_q;
    bus.lsb_rdata = (bus.lsb_done && !we) ? load_ext : lsb_rdata_q;
    bus.mem_busy  = (state != IDLE);
  end

  // Datapath: latch the winning request, step the byte counter, assemble and keep results.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      cnt         <= 3'd0;
      nbytes      <= 3'd0;
      base        <= '0;
      wdata       <= 32'h0;
      rbuf        <= 32'h0;
      if_data_q   <= 32'h0;
      lsb_rdata_q <= 32'h0;
      funct3      <= 3'd0;
      we          <= 1'b0;
      own_lsb     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_if     <= 1'b1;
`endif
    end else if (rdy_in) begin
      case (state)
        IDLE: if (grant) begin
          cnt     <= 3'd0;
          rbuf    <= 32'h0;
          own_lsb <= pick_lsb;
`ifdef MEM_ARB_RR_EN
          last_if <= !pick_lsb;
`endif
          if (pick_lsb) begin
            base   <= bus.lsb_addr;
            wdata  <= bus.lsb_wdata;
            funct3 <= bus.lsb_funct3;
            we     <= bus.lsb_we;
            nbytes <= width_of(bus.lsb_funct3[1:0]);
          end else begin
            base   <= bus.if_addr;
            wdata  <= 32'h0;
            funct3 <= 3'b010;
            we     <= 1'b0;
            nbytes <= 3'd4;
          end
        end
        RD: if (!bus.flush) begin
          if (cnt != 3'd0)    rbuf[{cap_lane, 3'b000} +: 8] <= bus.mem_din;
          if (cnt != nbytes)  cnt <= cnt + 3'd1;
        end
        WR: if (!io_stall) cnt <= cnt + 3'd1;
        DONE: if (done_fire) begin
          if (!own_lsb) if_data_q   <= rbuf;
          else if (!we) lsb_rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the single byte-serial RAM/IO port and shares it between two requesters: instruction-fetch refill (icache miss, 4-byte reads) and the LSB (1/2/4-byte loads and stores).
- Serialises each multi-byte transfer, assembles or sign-extends read data, and splits store data into bytes.
- Honours io_buffer_full on the IO region and aborts speculative reads on flush.
- Sits between the icache/LSB and the top-level mem_din/mem_dout/mem_aout/mem_rw pins.

Parameters:
- ADDR_WIDTH, 32, address width.
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO space (subject to io_buffer_full).

Ports:
- clk  in  1  system clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; low freezes the block
- io_buffer_full  in  1  UART buffer full; blocks IO writes
- mem_din  in  8  RAM read byte, valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_aout  out  ADDR_WIDTH  RAM byte address
- mem_rw  out  1  1 = write
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word, little-endian
- lsb_req  in  1  LSB request, held until lsb_done
- lsb_we  in  1  1 = store
- lsb_addr  in  ADDR_WIDTH  byte address
- lsb_wdata  in  32  store data
- lsb_funct3  in  3  RV32I width/sign code
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load result, extended
- flush  in  1  misprediction flush
- mem_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_in == 0 at a rising edge):
  - State = IDLE; all registers cleared.
  - Outputs: mem_rw=0, mem_aout=0, mem_dout=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, mem_busy=0.
  - Reset mid-transfer discards the transfer; no done pulse is issued.
- States: IDLE, RD, WR, DONE.
- Grant (IDLE, cycle G):
  - Requests are sampled; the winner's address, data, funct3 and we are latched.
  - Number of bytes N = 1/2/4 for funct3[1:0] = 00/01/10. Fetch always uses N=4.
  - Next state: RD for reads, WR for stores.
- RD:
  - Cycles G+1..G+N: mem_aout = base+k, mem_rw = 0.
  - Byte k is captured from mem_din in cycle G+k+2, into bit lane [8k+7:8k].
  - After the last capture, go to DONE.
  - DONE (cycle G+N+2): pulse the requester's done for exactly 1 cycle with data valid. If_data, lsb_rdata hold their values afterwards. Next state IDLE.
- Load extension:
  - 000 LB and 001 LH: sign-extend.
  - 100 LBU and 101 LHU: zero-extend.
  - 010 LW: full word.
- WR:
  - Cycles G+1..G+N: mem_rw = 1, mem_aout = base+k, mem_dout = wdata[8k+7:8k].
  - lsb_done pulses in cycle G+N+1; then IDLE.
- IO stall: for a store with base >= IO_BASE, if io_buffer_full == 1 in a WR cycle:
  - Drive mem_rw = 0.
  - Hold k (the byte is retried next cycle).
- Arbitration: fixed priority, LSB > IF. No preemption of a transfer in progress.
- Back-to-back: a requester may re-assert in the cycle after its done pulse. Grant happens no earlier than the cycle after DONE/IDLE is re-entered.
- Flush:
  - Any read in RD aborts: next state IDLE, no done pulse, captured bytes discarded.
  - Stores ignore flush and complete.
  - Flush in IDLE suppresses any grant in that cycle.
  - Flush in DONE for a read suppresses the done pulse.
- rdy_in == 0:
  - All registers hold and mem_rw is forced 0.
  - mem_aout holds, so the in-flight read byte remains valid on resume.
  - A frozen write byte is re-issued on resume.
- Address arithmetic: base + k wraps modulo 2^ADDR_WIDTH.
- Misaligned addresses are legal and serialised byte-wise.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are pending in IDLE, the requester not granted last wins. The last-grant flag resets to IF, so the first tie goes to LSB.
- Undefined: fixed LSB > IF priority.

Test Plan:
- Fetch from if_addr = 0x1000, RAM bytes 13,05,00,00 → mem_aout 0x1000..0x1003 in G+1..G+4; if_done in G+6 with if_data = 0x00000513.
- LB from 0x20, RAM byte 0x80 → lsb_rdata = 0xFFFFFF80. LBU from 0x20 → 0x00000080. LH of 0xFF 0x7F → 0x00007FFF.
- SW of 0xDEADBEEF at 0x40 → mem_rw = 1 for 4 cycles with dout EF,BE,AD,DE at 0x40..0x43; lsb_done in G+5.
- SB of 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_rw held 0 for those 3 cycles; one write after; lsb_done 1 cycle later.
- if_req and lsb_req asserted together, twice back-to-back:
  - Fixed priority: LSB is granted both times.
  - With MEM_ARB_RR_EN: LSB first, then IF.
- Fetch in progress, flush asserted at G+3 → no if_done, mem_busy low at G+4. Store in progress with flush → store completes, lsb_done pulses.
